maze_explorer: RTL and testbench



---
 rtl/maze_explorer.sv | 208 ++++++++++++++++++++
 tb/tb_maze_explorer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_explorer.sv
`default_nettype none
// ============================================================================
//  Module   : maze_explorer
//  Purpose  : Depth-first search controller for a 16x16 one-bit maze memory.
//             Marks visited cells, keeps a 2-bit direction stack and streams
//             the found path over a valid/ready port.
//  Revision : 1.0  initial release
// ============================================================================
module maze_explorer #(
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 15,
  parameter int GOAL_Y  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] mem_x,
  output logic [3:0] mem_y,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_din,
  input  logic       mem_dout,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [3:0] cur_x,
  output logic [3:0] cur_y,
  output logic [8:0] depth,
  output logic       dir_valid,
  input  logic       dir_ready,
  output logic [1:0] dir_out
);

  localparam logic [3:0] c_START_X = START_X[3:0];
  localparam logic [3:0] c_START_Y = START_Y[3:0];
  localparam logic [3:0] c_GOAL_X  = GOAL_X[3:0];
  localparam logic [3:0] c_GOAL_Y  = GOAL_Y[3:0];

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_MARK  = 4'd1,
    S_PROBE = 4'd2,
    S_WAIT  = 4'd3,
    S_NEXT  = 4'd4,
    S_PUSH  = 4'd5,
    S_BACK  = 4'd6,
    S_DONE  = 4'd7,
    S_FAIL  = 4'd8
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_dir;
  logic [3:0] r_addr_x;
  logic [3:0] r_addr_y;
  logic [8:0] r_idx;
  logic [1:0] r_stack [0:255];

  logic [3:0] w_nb_x;
  logic [3:0] w_nb_y;
  logic       w_nb_ok;
  logic [7:0] w_top;
  logic [1:0] w_pop;
  logic       w_at_goal;

  assign w_at_goal = (cur_x == c_GOAL_X) && (cur_y == c_GOAL_Y);
  assign w_top     = depth[7:0] - 8'd1;
  assign w_pop     = r_stack[w_top];

  // Neighbour of the current cell in the direction being tried, with range check
  always_comb begin
    w_nb_x  = cur_x;
    w_nb_y  = cur_y;
    w_nb_ok = 1'b0;
    case (r_dir)
      2'd0: begin w_nb_x = cur_x + 4'd1; w_nb_ok = (cur_x != 4'd15); end
      2'd1: begin w_nb_y = cur_y - 4'd1; w_nb_ok = (cur_y != 4'd0);  end
      2'd2: begin w_nb_x = cur_x - 4'd1; w_nb_ok = (cur_x != 4'd0);  end
      default: begin w_nb_y = cur_y + 4'd1; w_nb_ok = (cur_y != 4'd15); end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and memory strobes
  always_comb begin
    w_state_nxt = r_state;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) w_state_nxt = S_MARK;
      end
      S_MARK: begin
        mem_wr      = 1'b1;
        w_state_nxt = w_at_goal ? S_DONE : S_PROBE;
      end
      S_PROBE: begin
        if (w_nb_ok) begin
          mem_rd      = 1'b1;
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_NEXT;
        end
      end
      S_WAIT:  w_state_nxt = mem_dout ? S_NEXT : S_PUSH;
      S_NEXT:  w_state_nxt = (r_dir == 2'd3) ? S_BACK : S_PROBE;
      S_PUSH:  w_state_nxt = S_MARK;
      S_BACK:  w_state_nxt = (depth == 9'd0) ? S_FAIL : S_NEXT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address bus: live address while strobing, last strobed address otherwise
  always_comb begin
    mem_din = mem_wr;
    mem_x   = r_addr_x;
    mem_y   = r_addr_y;
    if (mem_wr) begin
      mem_x = cur_x;
      mem_y = cur_y;
    end else if (mem_rd) begin
      mem_x = w_nb_x;
      mem_y = w_nb_y;
    end
  end

  // Search datapath: position, depth, direction, status flags and stream index
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x    <= c_START_X;
      cur_y    <= c_START_Y;
      depth    <= 9'd0;
      r_dir    <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      r_idx    <= 9'd0;
      r_addr_x <= 4'd0;
      r_addr_y <= 4'd0;
    end else begin
      if (mem_wr || mem_rd) begin
        r_addr_x <= mem_x;
        r_addr_y <= mem_y;
      end
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            done  <= 1'b0;
            fail  <= 1'b0;
            depth <= 9'd0;
            cur_x <= c_START_X;
            cur_y <= c_START_Y;
            busy  <= 1'b1;
            r_idx <= 9'd0;
          end else if (dir_valid && dir_ready) begin
            r_idx <= r_idx + 9'd1;
          end
        end
        S_MARK: begin
          r_dir <= 2'd0;
          if (w_at_goal) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        S_NEXT: r_dir <= r_dir + 2'd1;
        S_PUSH: begin
          depth <= depth + 9'd1;
          cur_x <= w_nb_x;
          cur_y <= w_nb_y;
        end
        S_BACK: begin
          if (depth == 9'd0) begin
            busy <= 1'b0;
            fail <= 1'b1;
          end else begin
            // Step back against the popped direction and resume from it
            depth <= depth - 9'd1;
            r_dir <= w_pop;
            case (w_pop)
              2'd0:    cur_x <= cur_x - 4'd1;
              2'd1:    cur_y <= cur_y + 4'd1;
              2'd2:    cur_x <= cur_x + 4'd1;
              default: cur_y <= cur_y - 4'd1;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Direction stack write port; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (r_state == S_PUSH) r_stack[depth[7:0]] <= r_dir;
  end

  assign dir_valid = (r_state == S_DONE) && (r_idx < depth);
  assign dir_out   = dir_valid ? r_stack[r_idx[7:0]] : 2'd0;

endmodule
`default_nettype wire

// File: tb/tb_maze_explorer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maze_explorer
//  Purpose  : Self-checking bench for maze_explorer with a behavioural maze
//             memory and a reference depth-first search.
//  Revision : 1.0  initial release
// ============================================================================
module tb_maze_explorer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, dir_ready;
  logic [3:0] mem_x, mem_y, cur_x, cur_y;
  logic       mem_rd, mem_wr, mem_din, busy, done, fail, dir_valid;
  logic       mem_dout = 1'b0;
  logic [8:0] depth;
  logic [1:0] dir_out;

  logic       start2, dir_ready2;
  logic [3:0] mem_x2, mem_y2, cur_x2, cur_y2;
  logic       mem_rd2, mem_wr2, mem_din2, busy2, done2, fail2, dir_valid2;
  logic       mem_dout2;
  logic [8:0] depth2;
  logic [1:0] dir_out2;
  assign mem_dout2 = 1'b0;

  maze_explorer dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_x(mem_x), .mem_y(mem_y), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .done(done), .fail(fail), .cur_x(cur_x), .cur_y(cur_y),
    .depth(depth), .dir_valid(dir_valid), .dir_ready(dir_ready), .dir_out(dir_out)
  );

  maze_explorer #(.START_X(5), .START_Y(5), .GOAL_X(5), .GOAL_Y(5)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .mem_x(mem_x2), .mem_y(mem_y2), .mem_rd(mem_rd2), .mem_wr(mem_wr2),
    .mem_din(mem_din2), .mem_dout(mem_dout2),
    .busy(busy2), .done(done2), .fail(fail2), .cur_x(cur_x2), .cur_y(cur_y2),
    .depth(depth2), .dir_valid(dir_valid2), .dir_ready(dir_ready2), .dir_out(dir_out2)
  );

  // Maze memory: bench load/clear port plus the DUT bus, read data one cycle late
  logic       mem [0:255];
  logic       mem_clr = 1'b0;
  logic       mem_ld  = 1'b0;
  logic [7:0] mem_ld_a = 8'd0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 1'b0;
    end else if (mem_ld) begin
      mem[mem_ld_a] <= 1'b1;
    end else begin
      if (mem_wr) mem[{mem_y, mem_x}] <= mem_din;
      if (mem_rd) mem_dout <= mem[{mem_y, mem_x}];
    end
  end

  // Write activity of the start==goal instance
  int         wr2_cnt = 0;
  logic [7:0] wr2_addr = 8'd0;
  always @(negedge clk) begin
    if (mem_wr2) begin
      wr2_cnt  <= wr2_cnt + 1;
      wr2_addr <= {mem_y2, mem_x2};
    end
  end

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string nm, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Reference DFS over a snapshot of the maze
  logic       mm [0:255];
  logic [1:0] mstack [0:255];
  logic [1:0] strm [0:255];
  int         mdepth;

  task automatic run_model(input int sx, input int sy, input int gx, input int gy);
    int cx, cy, d, nx, ny, p, guard;
    bit found;
    cx = sx; cy = sy; d = 0; mdepth = 0; guard = 0;
    mm[cy*16+cx] = 1'b1;
    while (guard < 100000) begin
      guard++;
      if (cx == gx && cy == gy) break;
      found = 1'b0;
      for (int dd = d; dd < 4 && !found; dd++) begin
        nx = cx; ny = cy;
        case (dd)
          0: nx = cx + 1;
          1: ny = cy - 1;
          2: nx = cx - 1;
          default: ny = cy + 1;
        endcase
        if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && mm[ny*16+nx] == 1'b0) begin
          mstack[mdepth] = dd[1:0];
          mdepth++;
          cx = nx; cy = ny; d = 0;
          mm[ny*16+nx] = 1'b1;
          found = 1'b1;
        end
      end
      if (!found) begin
        if (mdepth == 0) break;
        mdepth--;
        p = int'(mstack[mdepth]);
        case (p)
          0: cx = cx - 1;
          1: cy = cy + 1;
          2: cx = cx + 1;
          default: cy = cy - 1;
        endcase
        d = p + 1;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic clear_mem();
    @(negedge clk); mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0;
  endtask

  task automatic load_cell(input int x, input int y);
    @(negedge clk); mem_ld = 1'b1; mem_ld_a = 8'(y*16 + x);
  endtask

  task automatic end_load();
    @(negedge clk); mem_ld = 1'b0;
  endtask

  // Wait for completion while checking bus rules every cycle
  task automatic wait_end(input int budget);
    int c;
    logic [7:0] prev_a;
    c = 0;
    prev_a = {mem_y, mem_x};
    while (!(done || fail) && c < budget) begin
      @(negedge clk);
      c++;
      if (mem_wr) begin
        check("rd_wr_exclusive", int'(mem_rd), 0);
        check("din_is_one", int'(mem_din), 1);
      end else if (!mem_rd) begin
        check("addr_hold", int'({mem_y, mem_x}), int'(prev_a));
      end
      prev_a = {mem_y, mem_x};
    end
    check("finished_in_budget", int'(done || fail), 1);
  endtask

  // Drain the path stream, stalling 5 cycles at index 3
  task automatic stream_check(input int n_exp);
    int n, cyc, stall;
    logic [1:0] held;
    n = 0; cyc = 0; stall = 5; held = 2'd0;
    while (n < n_exp && cyc < n_exp*2 + 50) begin
      @(negedge clk);
      cyc++;
      if (n == 3 && stall > 0) begin
        if (stall == 5) held = dir_out;
        else check("stall_dir_out", int'(dir_out), int'(held));
        check("stall_dir_valid", int'(dir_valid), 1);
        dir_ready = 1'b0;
        stall--;
      end else if (dir_valid) begin
        check("path_step", int'(dir_out), int'(mstack[n]));
        strm[n] = dir_out;
        n++;
        dir_ready = 1'b1;
      end else begin
        check("dir_valid_early_drop", int'(dir_valid), 1);
        dir_ready = 1'b0;
        cyc = 1 << 20;
      end
    end
    @(negedge clk);
    check("handshakes", n, n_exp);
    check("dir_valid_after_last", int'(dir_valid), 0);
    dir_ready = 1'b0;
  endtask

  typedef struct {
    int kind;     // 0 open, 1 wall column x=1, 2 dead end at (1,0), 3 goal sealed
    int clr;      // clear memory before the run
    int e_done;
    int e_fail;
    int e_depth;  // -1: take depth from the reference search
    int e_x;
    int e_y;
  } scen_t;

  scen_t tab [5];

  initial begin
    int exp_depth, cx, cy, hits;
    bit seen;

    tab[0] = '{0, 1, 1, 0, 240, 15, 15};
    tab[1] = '{0, 0, 0, 1, 0, 0, 0};
    tab[2] = '{1, 1, 0, 1, 0, 0, 0};
    tab[3] = '{2, 1, 1, 0, -1, 15, 15};
    tab[4] = '{3, 1, 0, 1, 0, 0, 0};

    rst = 1'b1; start = 1'b0; start2 = 1'b0; dir_ready = 1'b0; dir_ready2 = 1'b0;
    @(negedge clk); mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fail", int'(fail), 0);
    check("rst_depth", int'(depth), 0);
    check("rst_cur", int'({cur_y, cur_x}), 0);
    check("rst_strobes", int'({mem_rd, mem_wr}), 0);
    check("rst_addr", int'({mem_y, mem_x}), 0);
    check("rst_stream", int'({dir_valid, dir_out}), 0);
    check("rst_cur2", int'({cur_y2, cur_x2}), 8'h55);
    rst = 1'b0;

    // start == goal: a single mark and immediate completion
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    @(negedge clk);
    check("sg_done", int'(done2), 1);
    check("sg_busy", int'(busy2), 0);
    check("sg_depth", int'(depth2), 0);
    check("sg_wr_count", wr2_cnt, 1);
    check("sg_wr_addr", int'(wr2_addr), 8'h55);
    dir_ready2 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("sg_no_valid", int'(dir_valid2), 0);
    end
    dir_ready2 = 1'b0;

    for (int s = 0; s < 5; s++) begin
      if (tab[s].clr != 0) clear_mem();
      case (tab[s].kind)
        1: for (int y = 0; y < 16; y++) load_cell(1, y);
        2: begin load_cell(1, 1); load_cell(2, 1); load_cell(3, 1); load_cell(2, 0); end
        3: begin load_cell(14, 15); load_cell(15, 14); end
        default: ;
      endcase
      end_load();
      for (int i = 0; i < 256; i++) mm[i] = mem[i];
      run_model(0, 0, 15, 15);
      exp_depth = (tab[s].e_depth < 0) ? mdepth : tab[s].e_depth;

      pulse_start();
      wait_end(20000);
      check("end_done", int'(done), tab[s].e_done);
      check("end_fail", int'(fail), tab[s].e_fail);
      check("end_busy", int'(busy), 0);
      check("end_depth", int'(depth), exp_depth);
      check("end_cur_x", int'(cur_x), tab[s].e_x);
      check("end_cur_y", int'(cur_y), tab[s].e_y);

      if (tab[s].e_done != 0) begin
        stream_check(exp_depth);
        cx = 0; cy = 0; hits = 0;
        check("path_cell_marked", int'(mem[0]), 1);
        for (int k = 0; k < exp_depth; k++) begin
          case (mstack[k])
            2'd0: cx++;
            2'd1: cy--;
            2'd2: cx--;
            default: cy++;
          endcase
          if (cx == 1 && cy == 0) hits++;
          check("path_cell_marked", int'(mem[cy*16+cx]), 1);
        end
        if (tab[s].kind == 0) begin
          for (int k = 0; k < 240; k++)
            check("snake_step", int'(strm[k]),
                  (k % 16 == 15) ? 3 : (((k / 16) % 2 == 0) ? 0 : 2));
        end
        if (tab[s].kind == 2) begin
          check("dead_end_entered", int'(mem[1]), 1);
          check("first_step_down", int'(strm[0]), 3);
          check("path_avoids_1_0", hits, 0);
        end
      end else begin
        dir_ready = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check("no_valid_on_fail", int'(dir_valid), 0);
        end
        dir_ready = 1'b0;
        if (tab[s].kind == 1)
          for (int y = 0; y < 16; y++) check("column0_marked", int'(mem[y*16]), 1);
      end
    end

    // Reset during WAIT aborts; a fresh start then completes the open maze
    clear_mem();
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (mem_rd) seen = 1'b1;
    end
    check("probe_seen", int'(seen), 1);
    @(negedge clk);
    check("in_wait_strobes", int'({mem_rd, mem_wr}), 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_flags", int'({busy, done, fail}), 0);
    check("abort_strobes", int'({mem_rd, mem_wr}), 0);
    check("abort_depth", int'(depth), 0);
    check("abort_cur", int'({cur_y, cur_x}), 0);
    rst = 1'b0;
    pulse_start();
    wait_end(20000);
    check("rerun_done", int'(done), 1);
    check("rerun_depth", int'(depth), 240);
    check("rerun_cur", int'({cur_y, cur_x}), 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
